// File: rtl/mul64_seq_pkg.sv
// Shared constants and state encoding for the mul64_seq shift-add multiplier.
package mul64_seq_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul64_seq_cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups with the group carry
// chained between groups.
module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ci,
  output logic [63:0] sum,
  output logic        co
);

  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < 16; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group carry-out from group generate/propagate.
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum = p ^ c[63:0];
  assign co  = c[64];

endmodule

// File: rtl/mul64_seq.sv
// Sequential unsigned 64x64->128 radix-2 shift-add multiplier (64 iterations).
// Optional macro MUL_HI_OVF_EN adds result_ovf (product does not fit 64 bits).
module mul64_seq
  import mul64_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
`ifdef MUL_HI_OVF_EN
  output logic               result_ovf,
`endif
  output logic               busy,
  output logic               op_done,
  output mul_state_t         dbg_state
);

  // Handshake: op_start is accepted on an edge where the block is in IDLE or
  // DONE (busy low) and op_clear is low; it is ignored while busy. op_clear
  // wins over op_start. op_done stays high until the next start or clear.

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_t         state_q;
  mul_state_t         state_d;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic               start_ok;
  logic               last_iter;

  assign start_ok  = op_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_iter = (state_q == ST_EXEC) && (cnt_q == LAST_ITER);

  // Multiplicand is added into the upper half only when the LSB of P is set.
  assign add_b = m_q & {WIDTH{p_q[0]}};

  cla64 u_cla64 (
    .a   (p_q[2*WIDTH-1:WIDTH]),
    .b   (add_b),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  assign p_next = {add_co, add_sum, p_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (op_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (op_start)  state_d = ST_EXEC;
        ST_EXEC: if (last_iter) state_d = ST_DONE;
        ST_DONE: if (op_start)  state_d = ST_EXEC;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == ST_EXEC);
    op_done   = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (op_clear) begin
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (start_ok) begin
      m_q   <= multiplicand;
      p_q   <= {{WIDTH{1'b0}}, multiplier};
      cnt_q <= '0;
    end else if (state_q == ST_EXEC) begin
      p_q   <= p_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) result_q <= p_next;
    end
  end

  assign result = result_q;

`ifdef MUL_HI_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ovf_q <= 1'b0;
    else if (op_clear)  ovf_q <= 1'b0;
    else if (start_ok)  ovf_q <= 1'b0;
    else if (last_iter) ovf_q <= |p_next[2*WIDTH-1:WIDTH];
  end

  assign result_ovf = ovf_q;
`endif

endmodule
